// File: rtl/mont_exp_ctrl.sv
`default_nettype none
//==============================================================================
// mont_exp_ctrl : left-to-right square-and-multiply x^e mod m sequencer that
//                 drives a Montgomery multiplier over a start/done handshake.
// Revision      : 1.0
//==============================================================================
module mont_exp_ctrl #(
    parameter int N      = 512,
    parameter int E_BITS = 512,
    parameter int LW     = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [N-1:0]      in_x,
    input  logic [E_BITS-1:0] in_e,
    input  logic [LW-1:0]     in_e_len,
    input  logic [N-1:0]      in_m,
    input  logic [N-1:0]      in_r_mod_m,
    input  logic [N-1:0]      in_r2_mod_m,
    output logic [N-1:0]      result,
    output logic              done,
    output logic              mul_start,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    output logic [N-1:0]      mul_m,
    input  logic [N-1:0]      mul_result,
    input  logic              mul_done
);

    localparam int            IW       = (E_BITS > 1) ? $clog2(E_BITS) : 1;
    localparam logic [N-1:0]  c_one    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] c_e_max  = LW'(E_BITS);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD,
        S_ISSUE_TO_MONT, S_WAIT_TO_MONT,
        S_ISSUE_SQ, S_WAIT_SQ,
        S_ISSUE_MUL, S_WAIT_MUL,
        S_NEXT,
        S_ISSUE_FROM_MONT, S_WAIT_FROM_MONT,
        S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [N-1:0]      r_x, r_m, r_r2, r_xm, r_acc;
    logic [E_BITS-1:0] r_e;
    logic [IW-1:0]     r_idx;
    logic              r_len_zero;
    logic [N-1:0]      r_result, r_mul_a, r_mul_b, r_mul_m;
    logic              r_done, r_mul_start;

    logic [LW-1:0]     w_len;
    logic [N-1:0]      w_acc_nxt, w_a_nxt, w_b_nxt;
    logic              w_capture, w_ebit, w_issue;

    assign w_len     = (in_e_len > c_e_max) ? c_e_max : in_e_len;
    assign w_ebit    = r_e[r_idx];
    assign w_capture = mul_done && ((r_state == S_WAIT_SQ) || (r_state == S_WAIT_MUL) ||
                                    (r_state == S_WAIT_FROM_MONT));
    // Outputs are registered off the next state, so operands must see a result captured this cycle.
    assign w_acc_nxt = w_capture ? mul_result : r_acc;
    assign w_issue   = (w_state_nxt == S_ISSUE_TO_MONT) || (w_state_nxt == S_ISSUE_SQ) ||
                       (w_state_nxt == S_ISSUE_MUL) || (w_state_nxt == S_ISSUE_FROM_MONT);

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = w_acc_nxt;
        w_b_nxt     = w_acc_nxt;
        case (r_state)
            S_IDLE:            if (start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_state_nxt = S_ISSUE_TO_MONT;
                w_a_nxt     = r_x;
                w_b_nxt     = r_r2;
            end
            S_ISSUE_TO_MONT:   w_state_nxt = S_WAIT_TO_MONT;
            S_WAIT_TO_MONT: begin
                if (mul_done) begin
                    if (r_len_zero) begin
                        w_state_nxt = S_ISSUE_FROM_MONT;
                        w_b_nxt     = c_one;
                    end else begin
                        w_state_nxt = S_ISSUE_SQ;
                    end
                end
            end
            S_ISSUE_SQ:        w_state_nxt = S_WAIT_SQ;
            S_WAIT_SQ: begin
                if (mul_done) begin
                    if (w_ebit) begin
                        w_state_nxt = S_ISSUE_MUL;
                        w_b_nxt     = r_xm;
                    end else begin
                        w_state_nxt = S_NEXT;
                    end
                end
            end
            S_ISSUE_MUL:       w_state_nxt = S_WAIT_MUL;
            S_WAIT_MUL:        if (mul_done) w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (r_idx == '0) begin
                    w_state_nxt = S_ISSUE_FROM_MONT;
                    w_b_nxt     = c_one;
                end else begin
                    w_state_nxt = S_ISSUE_SQ;
                end
            end
            S_ISSUE_FROM_MONT: w_state_nxt = S_WAIT_FROM_MONT;
            S_WAIT_FROM_MONT:  if (mul_done) w_state_nxt = S_DONE;
            S_DONE:            w_state_nxt = S_IDLE;
            default:           w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_m         <= '0;
            r_r2        <= '0;
            r_xm        <= '0;
            r_acc       <= '0;
            r_e         <= '0;
            r_idx       <= '0;
            r_len_zero  <= 1'b0;
            r_result    <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_m     <= '0;
            r_done      <= 1'b0;
            r_mul_start <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mul_start <= w_issue;
            r_done      <= (w_state_nxt == S_DONE);
            r_acc       <= w_acc_nxt;
            if (w_issue) begin
                r_mul_a <= w_a_nxt;
                r_mul_b <= w_b_nxt;
                r_mul_m <= r_m;
            end
            if (w_state_nxt == S_DONE) r_result <= w_acc_nxt;
            if ((r_state == S_WAIT_TO_MONT) && mul_done) r_xm <= mul_result;
            if ((r_state == S_NEXT) && (r_idx != '0)) r_idx <= r_idx - 1'b1;
            if ((r_state == S_IDLE) && start) begin
                r_x        <= in_x;
                r_e        <= in_e;
                r_m        <= in_m;
                r_r2       <= in_r2_mod_m;
                r_acc      <= in_r_mod_m;
                r_idx      <= IW'(w_len - 1'b1);
                r_len_zero <= (w_len == '0);
            end
        end
    end

    assign result    = r_result;
    assign done      = r_done;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_m     = r_mul_m;

endmodule
`default_nettype wire

// File: tb/tb_mont_exp_ctrl.sv
`default_nettype none
//==============================================================================
// tb_mont_exp_ctrl : directed bench with a behavioural Montgomery multiplier
//                    and a normal-domain modexp reference.
// Revision         : 1.0
//==============================================================================
module tb_mont_exp_ctrl;

    localparam int N      = 512;
    localparam int E_BITS = 512;
    localparam int LW     = 10;
    typedef logic [2*N+1:0] wide_t;

    logic              clk = 1'b0;
    logic              resetn, start;
    logic [N-1:0]      in_x, in_m, in_r_mod_m, in_r2_mod_m;
    logic [E_BITS-1:0] in_e;
    logic [LW-1:0]     in_e_len;
    logic [N-1:0]      result, mul_a, mul_b, mul_m;
    logic              done, mul_start;
    logic [N-1:0]      mul_result = '0;
    logic              mul_done   = 1'b0;

    int errors = 0;
    int checks = 0;

    // Multiplier model state (written only by the model process)
    int           pulses   = 0;
    int           pend     = 0;
    int           spur_ack = 0;
    logic [N-1:0] la, lb, lm, lres;
    // Model controls (written only by the main process)
    bit           var_lat  = 1'b0;
    int           spur_req = 0;

    always #5 clk = ~clk;

    mont_exp_ctrl #(.N(N), .E_BITS(E_BITS), .LW(LW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .in_e_len(in_e_len), .in_m(in_m),
        .in_r_mod_m(in_r_mod_m), .in_r2_mod_m(in_r2_mod_m),
        .result(result), .done(done),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    // a*b*2^-N mod m by bitwise REDC
    function automatic logic [N-1:0] mont(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] m);
        wide_t t = wide_t'(a) * wide_t'(b);
        for (int k = 0; k < N; k++) begin
            if (t[0]) t = t + wide_t'(m);
            t = t >> 1;
        end
        if (t >= wide_t'(m)) t = t - wide_t'(m);
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] modexp(input logic [N-1:0] x, input logic [E_BITS-1:0] e,
                                            input int len, input logic [N-1:0] m);
        wide_t r = wide_t'(1) % wide_t'(m);
        for (int k = len - 1; k >= 0; k--) begin
            r = (r * r) % wide_t'(m);
            if (e[k]) r = (r * wide_t'(x)) % wide_t'(m);
        end
        return r[N-1:0];
    endfunction

    task automatic rmods(input logic [N-1:0] m, output logic [N-1:0] rm, output logic [N-1:0] r2);
        wide_t t = (wide_t'(1) << N) % wide_t'(m);
        rm = t[N-1:0];
        t  = (t * t) % wide_t'(m);
        r2 = t[N-1:0];
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Multiplier: mul_done arrives L+1 cycles after the mul_start cycle (L idle waits)
    always @(negedge clk) begin
        mul_done = 1'b0;
        if (!resetn) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mul_done   = 1'b1;
                    mul_result = lres;
                end
            end
            if (mul_start) begin
                pulses++;
                la   = mul_a;
                lb   = mul_b;
                lm   = mul_m;
                lres = mont(mul_a, mul_b, mul_m);
                pend = (var_lat ? int'($urandom_range(1, 20)) : 5) + 1;
            end
        end
        if (spur_req != spur_ack) begin
            spur_ack   = spur_req;
            mul_done   = 1'b1;
            mul_result = '1;
        end
    end

    // Advance one cycle and check operand stability while an op is outstanding
    task automatic step();
        @(posedge clk);
        #1;
        if (pend > 0) begin
            chk("wait_mul_a", mul_a, la);
            chk("wait_mul_b", mul_b, lb);
            chk("wait_mul_m", mul_m, lm);
            chk_i("wait_no_start", int'(mul_start), 0);
        end
    endtask

    task automatic run(input string tag, input logic [N-1:0] x, input logic [E_BITS-1:0] e,
                       input logic [LW-1:0] len, input logic [N-1:0] m,
                       input logic [N-1:0] exp_res, input int exp_pulses,
                       input int exp_cycles, input bit ignore_mode);
        int           p0, n;
        logic [N-1:0] rm, r2, res0;
        bit           seen;
        rmods(m, rm, r2);
        in_x = x; in_e = e; in_e_len = len; in_m = m;
        in_r_mod_m = rm; in_r2_mod_m = r2;
        p0 = pulses;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!done && n < 40000) begin
            if (ignore_mode && n == 20) begin
                in_x = ~x; in_e = '0; in_e_len = LW'(1); in_m = m + 2;
                start = 1'b1;
            end
            step();
            n++;
        end
        start = 1'b0;
        seen  = done;
        chk_i({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_result"}, result, exp_res);
        chk_i({tag, "_pulses"}, pulses - p0, exp_pulses);
        if (exp_cycles >= 0) chk_i({tag, "_cycles"}, n, exp_cycles);
        res0 = result;
        step();
        chk_i({tag, "_done_width"}, int'(done), 0);
        repeat (9) step();
        chk({tag, "_result_hold"}, result, res0);
        chk_i({tag, "_no_extra_start"}, pulses - p0, exp_pulses);
    endtask

    initial begin
        logic [N-1:0]      rm, r2, m_rand, x_rand;
        logic [E_BITS-1:0] e_rand, e_mask;
        wide_t             tmp;
        int                p0, n, np;

        resetn = 1'b0; start = 1'b0;
        in_x = '0; in_e = '0; in_e_len = '0; in_m = '0; in_r_mod_m = '0; in_r2_mod_m = '0;
        repeat (3) step();
        resetn = 1'b1;
        step();
        chk("reset_result", result, '0);
        chk_i("reset_done", int'(done), 0);
        chk_i("reset_mul_start", int'(mul_start), 0);
        chk("reset_mul_a", mul_a, '0);
        chk("reset_mul_b", mul_b, '0);
        chk("reset_mul_m", mul_m, '0);

        // Pin the reference models with hand-computed values
        chk("model_modexp_4_13", modexp(N'(4), E_BITS'(13), 4, N'(497)), N'(445));
        rmods(N'(497), rm, r2);
        chk("model_mont_one", mont(rm, N'(5), N'(497)), N'(5));

        run("basic", N'(4), E_BITS'(13), LW'(4), N'(497), N'(445), 9, 9 * 7 + 4 + 2, 1'b0);
        run("len0", N'(7), E_BITS'(0), LW'(0), N'(11), N'(1), 2, 2 * 7 + 0 + 2, 1'b0);
        run("ignore_start", N'(4), E_BITS'(13), LW'(4), N'(497), N'(445), 9, 69, 1'b1);

        // Spurious mul_done while idle
        p0 = pulses;
        spur_req++;
        repeat (6) step();
        chk_i("spur_no_start", pulses - p0, 0);
        chk_i("spur_no_done", int'(done), 0);
        chk("spur_result_kept", result, N'(445));

        // Reset during the third squaring wait
        rmods(N'(497), rm, r2);
        in_x = N'(4); in_e = E_BITS'(13); in_e_len = LW'(4); in_m = N'(497);
        in_r_mod_m = rm; in_r2_mod_m = r2;
        p0 = pulses;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while ((pulses - p0) < 6 && n < 300) begin
            step();
            n++;
        end
        chk_i("rst_reached_sq3", pulses - p0, 6);
        resetn = 1'b0;
        step();
        chk("rst_result", result, '0);
        chk_i("rst_done", int'(done), 0);
        chk_i("rst_mul_start", int'(mul_start), 0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_mul_b", mul_b, '0);
        chk("rst_mul_m", mul_m, '0);
        resetn = 1'b1;
        p0 = pulses;
        repeat (30) step();
        chk_i("rst_quiet", pulses - p0, 0);

        // High exponent bits beyond len must be ignored
        e_mask = '1;
        e_mask[3:0] = 4'b1101;
        run("mask_recover", N'(4), e_mask, LW'(4), N'(497), N'(445), 9, 69, 1'b0);

        // Full-width random operands
        for (int k = 0; k < N / 32; k++) begin
            m_rand[k*32 +: 32] = $urandom;
            x_rand[k*32 +: 32] = $urandom;
            e_rand[k*32 +: 32] = $urandom;
        end
        m_rand[0]   = 1'b1;
        m_rand[N-1] = 1'b1;
        tmp    = wide_t'(x_rand) % wide_t'(m_rand);
        x_rand = tmp[N-1:0];
        np     = 2 + E_BITS + $countones(e_rand);
        run("random512", x_rand, e_rand, LW'(E_BITS), m_rand, modexp(x_rand, e_rand, E_BITS, m_rand),
            np, np * 7 + E_BITS + 2, 1'b0);

        // Clamped length with variable multiplier latency
        var_lat = 1'b1;
        for (int k = 0; k < N / 32; k++) x_rand[k*32 +: 32] = $urandom;
        tmp    = wide_t'(x_rand) % wide_t'(m_rand);
        x_rand = tmp[N-1:0];
        e_mask = '1;
        run("clamp_varlat", x_rand, e_mask, LW'(1023), m_rand, modexp(x_rand, e_mask, E_BITS, m_rand),
            2 + 2 * E_BITS, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
